// File: rtl/vid_pkg.sv
// Purpose: shared types and constants for the raster timing generator.
// Contents: counter/divider widths, vclk source encodings, register field groups.
// Used by: vid_axis_cnt, vid_timing_gen.
package vid_pkg;

  localparam int CW   = 13;
  localparam int DIVW = 6;

  localparam logic [1:0] VCLK_LINE = 2'b00;
  localparam logic [1:0] VCLK_EXT  = 2'b01;

  typedef struct packed {
    logic            en;
    logic [DIVW-1:0] pcnt;
    logic [1:0]      vclk;
  } cr_t;

  typedef struct packed {
    logic [CW-1:0] hend;
    logic [CW-1:0] hsize;
  } h1_t;

  typedef struct packed {
    logic [CW-1:0] hss;
    logic [CW-1:0] hse;
  } h2_t;

  typedef struct packed {
    logic [CW-1:0] vend;
    logic [CW-1:0] vsize;
  } v1_t;

  typedef struct packed {
    logic [CW-1:0] vss;
    logic [CW-1:0] vse;
  } v2_t;

endpackage

// File: rtl/vid_axis_cnt.sv
// Purpose: one raster axis (h or v): position counter plus registered blank/sync decode.
// Ports: clk/reset, clr (hold at 0, force decode to idle), adv/limit (step and wrap point),
//        size/ss/se (decode thresholds), cnt (live counter), pos/blank/sync (registered), wrap.
module vid_axis_cnt
  import vid_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  input  logic [CW-1:0] limit,
  input  logic [CW-1:0] size,
  input  logic [CW-1:0] ss,
  input  logic [CW-1:0] se,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] pos,
  output logic          blank,
  output logic          sync,
  output logic          wrap
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pos_q, pos_d;
  logic          blank_q, blank_d;
  logic          sync_q, sync_d;

  always_comb begin
    wrap    = adv && (cnt_q == limit);
    cnt_d   = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (adv)
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    // Decode samples the pre-advance count so the strobes describe the position
    // that was current when the pixel tick fired.
    pos_d   = cnt_q;
    blank_d = (cnt_q >= size);
    sync_d  = (cnt_q >= ss) && (cnt_q < se);
    if (clr) begin
      pos_d   = '0;
      blank_d = 1'b1;
      sync_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      blank_q <= 1'b1;
      sync_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign cnt   = cnt_q;
  assign pos   = pos_q;
  assign blank = blank_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Purpose: raster timing generator: pixel divider, config shadow, h/v counters, sync/blank strobes.
// Ports: clk/reset, CR fields (en, pcnt, vclk), ext_vtick, H1/H2/V1/V2 fields in;
//        pix_tick, hcnt/vcnt, pix_valid, line_start, frame_start, hsync/hblank, vsync/vblank out.
module vid_timing_gen
  import vid_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DIVW-1:0] pcnt,
  input  logic [1:0]      vclk,
  input  logic            ext_vtick,
  input  logic [CW-1:0]   hend,
  input  logic [CW-1:0]   hsize,
  input  logic [CW-1:0]   hss,
  input  logic [CW-1:0]   hse,
  input  logic [CW-1:0]   vend,
  input  logic [CW-1:0]   vsize,
  input  logic [CW-1:0]   vss,
  input  logic [CW-1:0]   vse,
  output logic            pix_tick,
  output logic [CW-1:0]   hcnt,
  output logic [CW-1:0]   vcnt,
  output logic            pix_valid,
  output logic            line_start,
  output logic            frame_start,
  output logic            hsync,
  output logic            hblank,
  output logic            vsync,
  output logic            vblank
);

  logic [DIVW-1:0] div_q, div_d;
  logic            en_q, en_d;
  logic            pix_tick_q, pix_tick_d;
  h1_t             h1_q, h1_d;
  h2_t             h2_q, h2_d;
  v1_t             v1_q, v1_d;
  v2_t             v2_q, v2_d;

  logic load, run, tick, v_adv, h_wrap, v_wrap;
  logic [CW-1:0] h_cnt_live, v_cnt_live;

  always_comb begin
    // The enable-rise cycle only loads the shadow; ticking starts the clock after,
    // so the first pixel already sees the freshly captured geometry.
    load  = en && !en_q;
    run   = en && !en_q ? 1'b0 : en;
    tick  = run && (div_q == pcnt);
    v_adv = (vclk == VCLK_EXT) ? (run && ext_vtick) : h_wrap;

    en_d  = en;
    div_d = div_q + 1'b1;
    if (!run || tick || (div_q > pcnt))
      div_d = '0;

    pix_tick_d = tick;

    h1_d = h1_q;
    h2_d = h2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    if (load || (h_wrap && v_wrap)) begin
      h1_d = '{hend: hend, hsize: hsize};
      h2_d = '{hss: hss, hse: hse};
      v1_d = '{vend: vend, vsize: vsize};
      v2_d = '{vss: vss, vse: vse};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      en_q       <= 1'b0;
      pix_tick_q <= 1'b0;
      h1_q       <= '0;
      h2_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
    end else begin
      div_q      <= div_d;
      en_q       <= en_d;
      pix_tick_q <= pix_tick_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
    end
  end

  vid_axis_cnt u_h (
    .clk   (clk),
    .reset (reset),
    .clr   (!en),
    .adv   (tick),
    .limit (h1_q.hend),
    .size  (h1_q.hsize),
    .ss    (h2_q.hss),
    .se    (h2_q.hse),
    .cnt   (h_cnt_live),
    .pos   (hcnt),
    .blank (hblank),
    .sync  (hsync),
    .wrap  (h_wrap)
  );

  vid_axis_cnt u_v (
    .clk   (clk),
    .reset (reset),
    .clr   (!en),
    .adv   (v_adv),
    .limit (v1_q.vend),
    .size  (v1_q.vsize),
    .ss    (v2_q.vss),
    .se    (v2_q.vse),
    .cnt   (v_cnt_live),
    .pos   (vcnt),
    .blank (vblank),
    .sync  (vsync),
    .wrap  (v_wrap)
  );

  // Pulses are built from registered state, so they line up with hcnt/vcnt and the strobes.
  assign pix_tick    = pix_tick_q;
  assign pix_valid   = pix_tick_q && !hblank && !vblank;
  assign line_start  = pix_tick_q && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);

  logic unused_live;
  assign unused_live = ^{h_cnt_live, v_cnt_live};

endmodule

// File: tb/tb_vid_timing_gen.sv
module tb_vid_timing_gen;

  logic        clk = 1'b0;
  logic        reset, en, ext_vtick;
  logic [5:0]  pcnt;
  logic [1:0]  vclk;
  logic [12:0] hend, hsize, hss, hse, vend, vsize, vss, vse;
  logic        pix_tick, pix_valid, line_start, frame_start, hsync, hblank, vsync, vblank;
  logic [12:0] hcnt, vcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vid_timing_gen dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt), .vclk(vclk), .ext_vtick(ext_vtick),
    .hend(hend), .hsize(hsize), .hss(hss), .hse(hse),
    .vend(vend), .vsize(vsize), .vss(vss), .vse(vse),
    .pix_tick(pix_tick), .hcnt(hcnt), .vcnt(vcnt), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank)
  );

  typedef struct {
    int   k;
    int   h, v;
    bit   hb, hs, vb, vs, ls, fs, pv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int k, int h, int v, bit hb, bit hs, bit vb, bit vs,
                              bit ls, bit fs, bit pv);
    vec_t r;
    r.k = k; r.h = h; r.v = v; r.hb = hb; r.hs = hs; r.vb = vb; r.vs = vs;
    r.ls = ls; r.fs = fs; r.pv = pv;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_geom();
    pcnt = 0; vclk = 2'b00; ext_vtick = 0;
    hend = 9; hsize = 8; hss = 8; hse = 9;
    vend = 4; vsize = 3; vss = 3; vse = 4;
  endtask

  task automatic do_reset();
    en = 1; reset = 1;
    cyc(2);
    reset = 0;
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (frame_start) ok = 1;
    end
    chk("frame_start_wait", ok, 1);
  endtask

  // Called at the negedge where k==0 (a frame_start sample).
  task automatic apply_vecs(input string tag);
    int cur;
    cur = 0;
    foreach (vecs[i]) begin
      cyc(vecs[i].k - cur);
      cur = vecs[i].k;
      chk({tag, "_hcnt"}, hcnt, vecs[i].h);
      chk({tag, "_vcnt"}, vcnt, vecs[i].v);
      chk({tag, "_tick"}, pix_tick, 1);
      chk({tag, "_hblank"}, hblank, vecs[i].hb);
      chk({tag, "_hsync"}, hsync, vecs[i].hs);
      chk({tag, "_vblank"}, vblank, vecs[i].vb);
      chk({tag, "_vsync"}, vsync, vecs[i].vs);
      chk({tag, "_line_start"}, line_start, vecs[i].ls);
      chk({tag, "_frame_start"}, frame_start, vecs[i].fs);
      chk({tag, "_pix_valid"}, pix_valid, vecs[i].pv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hcnt"}, hcnt, 0);
    chk({tag, "_vcnt"}, vcnt, 0);
    chk({tag, "_hblank"}, hblank, 1);
    chk({tag, "_vblank"}, vblank, 1);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_tick"}, pix_tick, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
  endtask

  int n_tick, n_pv, n_fs, n_hs, n_hb, n_vb;
  int ev[5], evb[5], evs[5];
  bit found;

  initial begin
    set_geom();
    // ---- reset state
    en = 1; reset = 1;
    cyc(2);
    chk_idle("reset");
    chk("reset_line_start", line_start, 0);
    chk("reset_frame_start", frame_start, 0);
    reset = 0;

    // ---- test 1: pcnt=0 geometry
    wait_fs();
    vecs.delete();
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk( 7, 7, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 8, 8, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 9, 9, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(10, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(33, 3, 3, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(40, 0, 4, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(49, 9, 4, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(50, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    apply_vecs("t1");

    // ---- test 2: pcnt=3, one frame = 200 clocks
    set_geom(); pcnt = 3;
    do_reset();
    wait_fs();
    n_tick = 0; n_pv = 0; n_fs = 0;
    for (int k = 0; k < 200; k++) begin
      n_tick += int'(pix_tick);
      n_pv   += int'(pix_valid);
      n_fs   += int'(frame_start);
      @(negedge clk);
    end
    chk("t2_ticks_per_frame", n_tick, 50);
    chk("t2_valid_per_frame", n_pv, 24);
    chk("t2_fs_per_frame", n_fs, 1);
    chk("t2_fs_at_200", frame_start, 1);

    // ---- test 3: hend rewritten mid-frame
    set_geom();
    do_reset();
    wait_fs();
    hend = 19;
    vecs.delete();
    vecs.push_back(mk(10, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(49, 9, 4, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(50, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(60, 10, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(69, 19, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(70, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    apply_vecs("t3");

    // ---- test 4: external vertical strobe
    set_geom(); vclk = 2'b01;
    do_reset();
    cyc(25);
    chk("t4_vcnt_no_line_adv", vcnt, 0);
    ev  = '{1, 2, 3, 4, 0};
    evb = '{0, 0, 1, 1, 0};
    evs = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      ext_vtick = 1;
      cyc(1);
      ext_vtick = 0;
      cyc(1);
      chk($sformatf("t4_vcnt_%0d", i), vcnt, ev[i]);
      chk($sformatf("t4_vblank_%0d", i), vblank, evb[i]);
      chk($sformatf("t4_vsync_%0d", i), vsync, evs[i]);
      cyc(12);
      chk($sformatf("t4_vcnt_hold_%0d", i), vcnt, ev[i]);
    end

    // ---- test 5: degenerate hsync / hblank
    set_geom(); hss = 5; hse = 5; hsize = 15;
    do_reset();
    wait_fs();
    n_hs = 0; n_hb = 0; n_vb = 0;
    for (int k = 0; k < 100; k++) begin
      n_hs += int'(hsync);
      n_hb += int'(hblank);
      n_vb += int'(vblank);
      @(negedge clk);
    end
    chk("t5_hsync_count", n_hs, 0);
    chk("t5_hblank_count", n_hb, 0);
    chk("t5_vblank_count", n_vb, 40);

    // ---- test 6: en drop at (6,2), re-enable, reset mid-line
    set_geom();
    do_reset();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (hcnt == 6 && vcnt == 2) found = 1;
    end
    chk("t6_reach_6_2", found, 1);
    en = 0;
    cyc(1);
    chk_idle("t6_en_off");
    cyc(5);
    chk_idle("t6_en_off_hold");
    en = 1;
    cyc(1);
    chk("t6_reen_load_cycle", frame_start, 0);
    cyc(1);
    chk("t6_reen_frame_start", frame_start, 1);
    cyc(3);
    chk("t6_midline_hcnt", hcnt, 3);
    reset = 1;
    cyc(1);
    chk_idle("t6_reset");
    reset = 0;
    cyc(1);
    chk("t6_rst_load_cycle", frame_start, 0);
    cyc(1);
    chk("t6_rst_frame_start", frame_start, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
